// File: rtl/hyper_delay_pkg.sv
// Shared types for the HyperBus RX delay calibration path (tuner, delay line wrapper, CSRs).
package hyper_delay_pkg;

  localparam int unsigned CodeW = 4;

  typedef logic [CodeW-1:0] code_t;
  typedef logic [CodeW:0]   len_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_EVAL,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/hyper_delay_window.sv
// Longest-run tracker: one step per tap, taps numbered from 0 after clear.
// A closed run replaces the best only when strictly longer, so ties keep the lower window.
module hyper_delay_window #(
  parameter int unsigned DelayW = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              step_i,
  input  logic              pass_i,
  input  logic              last_i,
  output logic [DelayW-1:0] best_lo_o,
  output logic [DelayW:0]   best_len_o
);

  localparam int unsigned LenW = DelayW + 1;

  logic [DelayW-1:0] tap_q;
  logic [DelayW-1:0] run_lo_q, run_lo_n;
  logic [LenW-1:0]   run_len_q, run_len_n;
  logic [DelayW-1:0] best_lo_q;
  logic [LenW-1:0]   best_len_q;
  logic              close_run;

  always_comb begin
    run_lo_n  = run_lo_q;
    run_len_n = run_len_q;
    if (pass_i) begin
      if (run_len_q == '0) run_lo_n = tap_q;
      run_len_n = run_len_q + LenW'(1);
    end
  end

  // A passing last tap still closes its run so a window may end at the top code.
  assign close_run = step_i && (!pass_i || last_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tap_q      <= '0;
      run_lo_q   <= '0;
      run_len_q  <= '0;
      best_lo_q  <= '0;
      best_len_q <= '0;
    end else if (clear_i) begin
      tap_q      <= '0;
      run_lo_q   <= '0;
      run_len_q  <= '0;
      best_lo_q  <= '0;
      best_len_q <= '0;
    end else if (step_i) begin
      tap_q <= tap_q + DelayW'(1);
      if (close_run) begin
        if (run_len_n > best_len_q) begin
          best_lo_q  <= run_lo_n;
          best_len_q <= run_len_n;
        end
        run_len_q <= '0;
      end else begin
        run_lo_q  <= run_lo_n;
        run_len_q <= run_len_n;
      end
    end
  end

  assign best_lo_o  = best_lo_q;
  assign best_len_o = best_len_q;

endmodule

// File: rtl/hyper_delay_tune.sv
// RX delay calibration: sweeps all taps, collects checker verdicts, centres on the longest passing window.
// Handshake: sample_req_o is high exactly while in SAMPLE; each cycle with sample_valid_i high there consumes one verdict, verdicts elsewhere are dropped.
module hyper_delay_tune
  import hyper_delay_pkg::*;
#(
  parameter int unsigned DelayW        = 4,
  parameter int unsigned DefaultDelay  = 8,
  parameter int unsigned SettleCycles  = 8,
  parameter int unsigned SamplesPerTap = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              manual_en_i,
  input  logic [DelayW-1:0] manual_delay_i,
  output logic              sample_req_o,
  input  logic              sample_valid_i,
  input  logic              sample_pass_i,
  output logic [DelayW-1:0] delay_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              fail_o,
  output logic [DelayW-1:0] win_lo_o,
  output logic [DelayW-1:0] win_hi_o,
  output state_t            state_o
);

  localparam int unsigned LenW  = DelayW + 1;
  localparam int unsigned SetW  = $clog2(SettleCycles) + 1;
  localparam int unsigned SmpW  = $clog2(SamplesPerTap) + 1;
  localparam logic [DelayW-1:0] MaxTap = '1;

  state_t            state_q;
  logic [DelayW-1:0] tap_q;
  logic [SetW-1:0]   settle_cnt_q;
  logic [SmpW-1:0]   pass_cnt_q;
  logic              tap_pass_q;
  logic [DelayW-1:0] delay_q;
  logic [DelayW-1:0] applied_q;
  logic              busy_q, done_q, fail_q, req_q;
  logic [DelayW-1:0] win_lo_q, win_hi_q;

  logic              win_clear, win_step, win_last;
  logic [DelayW-1:0] best_lo;
  logic [LenW-1:0]   best_len;
  logic [DelayW-1:0] centre_code, hi_code;

  assign win_clear = (state_q == ST_IDLE) && start_i;
  assign win_step  = (state_q == ST_EVAL);
  assign win_last  = (tap_q == MaxTap);

  hyper_delay_window #(.DelayW(DelayW)) u_window (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (win_clear),
    .step_i     (win_step),
    .pass_i     (tap_pass_q),
    .last_i     (win_last),
    .best_lo_o  (best_lo),
    .best_len_o (best_len)
  );

  assign centre_code = best_lo + DelayW'((best_len - LenW'(1)) >> 1);
  assign hi_code     = best_lo + DelayW'(best_len - LenW'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      tap_q        <= '0;
      settle_cnt_q <= '0;
      pass_cnt_q   <= '0;
      tap_pass_q   <= 1'b0;
      delay_q      <= DelayW'(DefaultDelay);
      applied_q    <= DelayW'(DefaultDelay);
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      req_q        <= 1'b0;
      win_lo_q     <= '0;
      win_hi_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q      <= ST_SETTLE;
            tap_q        <= '0;
            delay_q      <= '0;
            settle_cnt_q <= '0;
            busy_q       <= 1'b1;
            fail_q       <= 1'b0;
            win_lo_q     <= '0;
            win_hi_q     <= '0;
          end else if (manual_en_i) begin
            delay_q   <= manual_delay_i;
            applied_q <= manual_delay_i;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_q == SetW'(SettleCycles - 1)) begin
            state_q    <= ST_SAMPLE;
            req_q      <= 1'b1;
            pass_cnt_q <= '0;
          end else begin
            settle_cnt_q <= settle_cnt_q + SetW'(1);
          end
        end
        ST_SAMPLE: begin
          if (sample_valid_i) begin
            if (!sample_pass_i) begin
              tap_pass_q <= 1'b0;
              req_q      <= 1'b0;
              state_q    <= ST_EVAL;
            end else if (pass_cnt_q == SmpW'(SamplesPerTap - 1)) begin
              tap_pass_q <= 1'b1;
              req_q      <= 1'b0;
              state_q    <= ST_EVAL;
            end else begin
              pass_cnt_q <= pass_cnt_q + SmpW'(1);
            end
          end
        end
        ST_EVAL: begin
          if (!win_last) begin
            tap_q        <= tap_q + DelayW'(1);
            delay_q      <= tap_q + DelayW'(1);
            settle_cnt_q <= '0;
            state_q      <= ST_SETTLE;
          end else begin
            done_q  <= 1'b1;
            state_q <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          // The tracker's best run settled on the EVAL edge, so it is final here.
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          if (best_len != '0) begin
            delay_q   <= centre_code;
            applied_q <= centre_code;
            win_lo_q  <= best_lo;
            win_hi_q  <= hi_code;
          end else begin
            fail_q   <= 1'b1;
            delay_q  <= applied_q;
            win_lo_q <= '0;
            win_hi_q <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sample_req_o = req_q;
  assign delay_o      = delay_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign fail_o       = fail_q;
  assign win_lo_o     = win_lo_q;
  assign win_hi_o     = win_hi_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_hyper_delay_tune.sv
// Bench for hyper_delay_tune: checker emulation driven from a per-tap pass mask, results scoreboarded.
module tb_hyper_delay_tune;
  import hyper_delay_pkg::*;

  localparam int W      = 13;  // {fail, delay, win_lo, win_hi}
  localparam int SETTLE = 8;
  localparam int SPT    = 4;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       start_i;
  logic       manual_en_i;
  logic [3:0] manual_delay_i;
  logic       sample_req_o;
  logic       sample_valid_i;
  logic       sample_pass_i;
  logic [3:0] delay_o;
  logic       busy_o;
  logic       done_o;
  logic       fail_o;
  logic [3:0] win_lo_o;
  logic [3:0] win_hi_o;
  state_t     state_o;

  hyper_delay_tune #(
    .DelayW(4), .DefaultDelay(8), .SettleCycles(SETTLE), .SamplesPerTap(SPT)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .manual_en_i    (manual_en_i),
    .manual_delay_i (manual_delay_i),
    .sample_req_o   (sample_req_o),
    .sample_valid_i (sample_valid_i),
    .sample_pass_i  (sample_pass_i),
    .delay_o        (delay_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .fail_o         (fail_o),
    .win_lo_o       (win_lo_o),
    .win_hi_o       (win_hi_o),
    .state_o        (state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Brute-force search over every [lo,hi]; ascending lo with strict '>' keeps the lower window on ties.
  function automatic logic [W-1:0] model(input logic [15:0] mask, input logic [3:0] prev);
    int best_lo = 0;
    int best_len = 0;
    for (int lo = 0; lo < 16; lo++) begin
      for (int hi = lo; hi < 16; hi++) begin
        bit ok = 1'b1;
        for (int t = lo; t <= hi; t++) if (!mask[t]) ok = 1'b0;
        if (ok && (hi - lo + 1) > best_len) begin
          best_lo  = lo;
          best_len = hi - lo + 1;
        end
      end
    end
    if (best_len == 0) return {1'b1, prev, 4'd0, 4'd0};
    return {1'b0, 4'(best_lo + (best_len - 1) / 2), 4'(best_lo), 4'(best_lo + best_len - 1)};
  endfunction

  function automatic int exp_cycles(input logic [15:0] eff, input int fail2);
    int n = 1;
    for (int t = 0; t < 16; t++) begin
      if (eff[t])         n += SETTLE + SPT + 1;
      else if (t == fail2) n += SETTLE + 2 + 1;
      else                n += SETTLE + 1 + 1;
    end
    return n;
  endfunction

  // driver + monitor for one calibration
  task automatic run_cal(input logic [15:0] mask, input bit gaps, input bit noise,
                         input int fail2, input int restart_at, input int abort_at);
    logic [15:0]  eff;
    logic [W-1:0] exp;
    int  cycles, done_cnt, viol_req, viol_samp, low_cnt, sidx;
    bit  tracking, prev_req, restarted, rs_pending, timeout, aborted, v, p;
    logic [3:0] prev_delay;
    eff = mask;
    if (fail2 >= 0) eff[fail2] = 1'b0;
    exp_q.push_back(model(eff, delay_o));

    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    check_eq("start_busy", busy_o, 1);
    check_eq("start_delay", delay_o, 0);
    check_eq("start_fail_clr", fail_o, 0);

    cycles = 1; done_cnt = 0; viol_req = 0; viol_samp = 0; low_cnt = 0; sidx = 0;
    tracking = 1; prev_req = 0; restarted = 0; rs_pending = 0; timeout = 1; aborted = 0;
    prev_delay = delay_o;
    for (int k = 0; k < 4000; k++) begin
      if (k > 0) begin
        if (!busy_o) begin timeout = 0; break; end
        cycles++;
        if (delay_o != prev_delay) begin tracking = 1; low_cnt = 0; end
        if (prev_req && sample_req_o && delay_o != prev_delay) viol_samp++;
      end
      if (done_o) done_cnt++;
      if (tracking) begin
        if (sample_req_o) begin
          if (low_cnt != SETTLE) viol_req++;
          tracking = 0;
        end else low_cnt++;
      end
      if (rs_pending) begin
        check_eq("restart_ignored_delay", delay_o, restart_at);
        check_eq("restart_ignored_busy", busy_o, 1);
        rs_pending = 0;
      end
      if (abort_at >= 0 && delay_o == 4'(abort_at)) begin
        #2 rst_ni = 1'b0;
        #1;
        check_eq("abort_delay", delay_o, 8);
        check_eq("abort_busy", busy_o, 0);
        check_eq("abort_req", sample_req_o, 0);
        check_eq("abort_state", 32'(state_o), 32'(ST_IDLE));
        sample_valid_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        aborted = 1;
        break;
      end
      if (restart_at >= 0 && !restarted && delay_o == 4'(restart_at)) begin
        start_i = 1'b1; restarted = 1; rs_pending = 1;
      end else start_i = 1'b0;
      if (sample_req_o) begin
        v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        p = 1'b0;
        if (v) begin
          sidx++;
          p = mask[delay_o];
          if (fail2 >= 0 && delay_o == 4'(fail2) && sidx == 2) p = 1'b0;
        end
        sample_valid_i = v;
        sample_pass_i  = p;
      end else begin
        sidx = 0;
        sample_valid_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        sample_pass_i  = 1'b0;
      end
      prev_req   = sample_req_o;
      prev_delay = delay_o;
      @(negedge clk_i);
    end
    sample_valid_i = 1'b0;
    start_i = 1'b0;

    if (aborted) begin
      void'(exp_q.pop_back());
      return;
    end
    check_eq("timeout", timeout, 0);
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", 1, 0);
      return;
    end
    exp = exp_q.pop_front();
    check_eq("res_fail", fail_o, exp[12]);
    check_eq("res_delay", delay_o, exp[11:8]);
    check_eq("res_win_lo", win_lo_o, exp[7:4]);
    check_eq("res_win_hi", win_hi_o, exp[3:0]);
    check_eq("done_pulses", done_cnt, 1);
    check_eq("done_low_after", done_o, 0);
    check_eq("settle_req_low", viol_req, 0);
    check_eq("delay_stable_in_sample", viol_samp, 0);
    if (!gaps) check_eq("busy_cycles", cycles, exp_cycles(eff, fail2));
  endtask

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; manual_en_i = 1'b0; manual_delay_i = 4'd0;
    sample_valid_i = 1'b0; sample_pass_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check_eq("rst_delay", delay_o, 8);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_done", done_o, 0);
    check_eq("rst_fail", fail_o, 0);
    check_eq("rst_req", sample_req_o, 0);
    check_eq("rst_win_lo", win_lo_o, 0);
    check_eq("rst_win_hi", win_hi_o, 0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    run_cal(16'h03F8, 0, 0, -1, -1, -1);  // 3..9
    run_cal(16'h3C0E, 0, 0, -1, -1, -1);  // 1..3 and 10..13
    run_cal(16'h0E1C, 0, 0, -1, -1, -1);  // tie 2..4 vs 9..11
    run_cal(16'hF000, 0, 0, -1, -1, -1);  // 12..15 at sweep end

    @(negedge clk_i);
    manual_en_i = 1'b1; manual_delay_i = 4'd5;
    @(negedge clk_i);
    manual_en_i = 1'b0;
    check_eq("manual_latency", delay_o, 5);
    run_cal(16'h0000, 0, 0, -1, -1, -1);  // all fail, falls back to 5
    run_cal(16'hFFFF, 1, 1, -1, -1, -1);  // full window with gaps and settle noise
    run_cal(16'h03F8, 0, 1, 6, -1, -1);   // tap 6 fails on its 2nd sample

    run_cal(16'hFFFF, 0, 0, -1, -1, 5);   // async reset mid-sweep
    check_eq("post_abort_delay", delay_o, 8);
    run_cal(16'h03F8, 0, 0, -1, 6, -1);   // start while busy

    for (int i = 0; i < 3; i++) run_cal(16'($urandom_range(0, 65535)), 0, 1, -1, -1, -1);

    check_eq("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
